// File: rtl/rv_pkg.sv
// Shared register-file types: address/data widths and the write-back entry
// carried through the execute-result FIFO.
package rv_pkg;

    localparam int REG_ADDR_W = 5;
    localparam int XLEN       = 32;
    localparam int NUM_REGS   = 1 << REG_ADDR_W;

    // One pending register-file write: destination and value.
    typedef struct packed {
        logic [REG_ADDR_W-1:0] rd;
        logic [XLEN-1:0]       data;
    } wb_entry_t;

    // Bits needed to count from 0 up to and including depth.
    function automatic int cnt_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with registered occupancy count. full/empty come from the
// registered count only, so a push on a full FIFO is refused even when a pop
// happens in the same cycle. DEPTH must be a power of two.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       push,
    input  logic [WIDTH-1:0]           push_data,
    input  logic                       pop,
    output logic [WIDTH-1:0]           pop_data,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]    count_q, count_d;
    logic             do_push, do_pop;

    assign full     = (count_q == CW'(DEPTH));
    assign empty    = (count_q == '0);
    assign count    = count_q;
    assign do_push  = push & ~full;
    assign do_pop   = pop & ~empty;
    assign pop_data = mem_q[rd_ptr_q];

    // Next pointers and occupancy; pointers wrap naturally at a power-of-two depth.
    always_comb begin
        // NOTE: every variable gets a default before any branch so no latch is inferred.
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (do_push) wr_ptr_d = wr_ptr_q + AW'(1);
        if (do_pop)  rd_ptr_d = rd_ptr_q + AW'(1);
        count_d = count_q + CW'(do_push) - CW'(do_pop);
    end

    // Pointer and count registers.
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Entry storage.
    // NOTE: the array is not reset; the count guarantees no slot is read before it is written.
    always_ff @(posedge clk) begin
        if (do_push) mem_q[wr_ptr_q] <= push_data;
    end

endmodule

// File: rtl/regs_writeback.sv
// Sole driver of the register-file write port. Execute results wait in a
// small FIFO; load destinations are reserved in issue order in a tag queue.
// A returning load always wins the port, because its response cannot be
// stalled. busy reports every register with a write still in flight.
module regs_writeback
    import rv_pkg::*;
#(
    parameter int EX_DEPTH = 2,
    parameter int LD_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  ex_valid,
    output logic                  ex_ready,
    input  logic [REG_ADDR_W-1:0] ex_rd,
    input  logic [XLEN-1:0]       ex_data,
    input  logic                  ld_req_valid,
    output logic                  ld_req_ready,
    input  logic [REG_ADDR_W-1:0] ld_req_rd,
    input  logic                  ld_rsp_valid,
    input  logic [XLEN-1:0]       ld_rsp_data,
    output logic                  wr_en,
    output logic [REG_ADDR_W-1:0] addrD,
    output logic [XLEN-1:0]       dataD,
    output logic [NUM_REGS-1:0]   busy,
    output logic                  ld_err
);

    // Per-register load count is wide enough for every tag slot to name the
    // same register; the EX count likewise covers a full EX FIFO.
    localparam int LC_W = (cnt_w(LD_DEPTH) > 2) ? cnt_w(LD_DEPTH) : 2;
    localparam int EC_W = cnt_w(EX_DEPTH);

    // FIFO interfaces
    wb_entry_t             ex_push_entry;
    wb_entry_t             ex_head;
    logic                  ex_full, ex_empty;
    logic [EC_W-1:0]       ex_count;
    logic [REG_ADDR_W-1:0] ld_head;
    logic                  ld_full, ld_empty;
    logic [cnt_w(LD_DEPTH)-1:0] ld_count;

    // Handshakes and selection
    logic      ex_push, ld_push;
    logic      ex_pop, ld_take;
    logic      sel_valid;
    wb_entry_t sel_entry;

    // Registered state
    logic                  wr_en_q, wr_en_d;
    logic [REG_ADDR_W-1:0] addr_q, addr_d;
    logic [XLEN-1:0]       data_q, data_d;
    logic                  ld_err_q, ld_err_d;
    logic [LC_W-1:0]       ld_cnt_q [NUM_REGS];
    logic [LC_W-1:0]       ld_cnt_d [NUM_REGS];
    logic [EC_W-1:0]       ex_cnt_q [NUM_REGS];
    logic [EC_W-1:0]       ex_cnt_d [NUM_REGS];

    // Occupancy counts are available for debug but not needed here.
    logic unused_counts;
    assign unused_counts = ^{ex_count, ld_count};

    assign ex_ready      = ~ex_full;
    assign ld_req_ready  = ~ld_full;
    assign ex_push       = ex_valid & ex_ready;
    assign ld_push       = ld_req_valid & ld_req_ready;
    assign ex_push_entry = '{rd: ex_rd, data: ex_data};

    sync_fifo #(
        .WIDTH ($bits(wb_entry_t)),
        .DEPTH (EX_DEPTH)
    ) u_ex_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (ex_push),
        .push_data (ex_push_entry),
        .pop       (ex_pop),
        .pop_data  (ex_head),
        .full      (ex_full),
        .empty     (ex_empty),
        .count     (ex_count)
    );

    sync_fifo #(
        .WIDTH (REG_ADDR_W),
        .DEPTH (LD_DEPTH)
    ) u_tag_queue (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (ld_push),
        .push_data (ld_req_rd),
        .pop       (ld_take),
        .pop_data  (ld_head),
        .full      (ld_full),
        .empty     (ld_empty),
        .count     (ld_count)
    );

    // Pick this cycle's write: load response first, else EX head. A response
    // with nothing reserved is flagged and still blocks the EX FIFO.
    always_comb begin
        sel_valid = 1'b0;
        sel_entry = '0;
        ld_take   = 1'b0;
        ex_pop    = 1'b0;
        ld_err_d  = ld_err_q;
        if (ld_rsp_valid) begin
            if (!ld_empty) begin
                ld_take   = 1'b1;
                sel_valid = 1'b1;
                sel_entry = '{rd: ld_head, data: ld_rsp_data};
            end else begin
                ld_err_d  = 1'b1;
            end
        end else if (!ex_empty) begin
            ex_pop    = 1'b1;
            sel_valid = 1'b1;
            sel_entry = ex_head;
        end
    end

    // Write-port next state; an x0 destination is consumed without a strobe.
    always_comb begin
        wr_en_d = sel_valid && (sel_entry.rd != '0);
        addr_d  = addr_q;
        data_d  = data_q;
        if (wr_en_d) begin
            addr_d = sel_entry.rd;
            data_d = sel_entry.data;
        end
    end

    // Per-register pending counts: up on reserve/accept, down on the pop that writes it.
    always_comb begin
        for (int r = 0; r < NUM_REGS; r++) begin
            ld_cnt_d[r] = ld_cnt_q[r];
            ex_cnt_d[r] = ex_cnt_q[r];
            if (r != 0) begin
                ld_cnt_d[r] = ld_cnt_q[r]
                            + LC_W'(ld_push && (ld_req_rd == REG_ADDR_W'(r)))
                            - LC_W'(ld_take && (ld_head == REG_ADDR_W'(r)));
                ex_cnt_d[r] = ex_cnt_q[r]
                            + EC_W'(ex_push && (ex_rd == REG_ADDR_W'(r)))
                            - EC_W'(ex_pop && (ex_head.rd == REG_ADDR_W'(r)));
            end
        end
    end

    // Busy straight from the counters so a bit drops as its write reaches the port.
    always_comb begin
        busy = '0;
        for (int r = 1; r < NUM_REGS; r++) begin
            busy[r] = (ld_cnt_q[r] != '0) || (ex_cnt_q[r] != '0);
        end
    end

    // Output, error and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_en_q  <= 1'b0;
            addr_q   <= '0;
            data_q   <= '0;
            ld_err_q <= 1'b0;
            for (int r = 0; r < NUM_REGS; r++) begin
                ld_cnt_q[r] <= '0;
                ex_cnt_q[r] <= '0;
            end
        end else begin
            wr_en_q  <= wr_en_d;
            addr_q   <= addr_d;
            data_q   <= data_d;
            ld_err_q <= ld_err_d;
            for (int r = 0; r < NUM_REGS; r++) begin
                ld_cnt_q[r] <= ld_cnt_d[r];
                ex_cnt_q[r] <= ex_cnt_d[r];
            end
        end
    end

    assign wr_en  = wr_en_q;
    assign addrD  = addr_q;
    assign dataD  = data_q;
    assign ld_err = ld_err_q;

endmodule
